// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame geometry and receive FSM states.
package ps2_pkg;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head entry is read combinationally.
module ps2_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Status flags, gated push/pop and next pointer values; a pop frees the slot a same-cycle push needs.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    level    = wr_ptr_q - rd_ptr_q;
    rdata    = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; only accepted pushes write it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronisers, ps2_clk glitch filter, frame FSM,
// sticky error flags and a scan-code FIFO with a pop interface.
// Optional feature macro: PS2_RX_TIMEOUT_EN aborts a stalled frame after TIMEOUT_CYC idle cycles.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [7:0]                    data,
  output logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err
);

  import ps2_pkg::*;

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic filt_q, filt_d;
  logic [CNT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic fall;

  rx_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic par_q, par_d;
  logic ovf_q, ovf_d, par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic set_ovf, set_par, set_frm, push;
  logic fifo_full, fifo_empty, pop_req;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
`endif

  assign pop_req = rd_en && !fifo_empty;

  // Two-flop synchronisers and saturating filter; fall fires on the edge the filtered level drops.
  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    filt_d     = filt_q;
    filt_cnt_d = '0;
    fall       = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
        fall   = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // Frame FSM next state, frame verdict at the stop bit and sticky flag updates (set beats clear).
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    push      = 1'b0;
    set_ovf   = 1'b0;
    set_par   = 1'b0;
    set_frm   = 1'b0;
    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {dat_s2_q, shift_q[PS2_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat_s2_q && odd_parity_ok(shift_q, par_q)) begin
            if (fifo_full && !pop_req) set_ovf = 1'b1;
            else                       push    = 1'b1;
          end
          if (!odd_parity_ok(shift_q, par_q)) set_par = 1'b1;
          if (!dat_s2_q)                      set_frm = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef PS2_RX_TIMEOUT_EN
    tmo_d = '0;
    if (!fall && state_q != IDLE) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE;
        set_frm = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
    ovf_d     = set_ovf | (ovf_q     & ~err_clr);
    par_err_d = set_par | (par_err_q & ~err_clr);
    frm_err_d = set_frm | (frm_err_q & ~err_clr);
  end

  // All receiver state: idle lines and filter reset high, FSM to IDLE, flags cleared.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ovf_q      <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ovf_q      <= ovf_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
`ifdef PS2_RX_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  ps2_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push),
    .pop   (rd_en),
    .wdata (shift_q),
    .rdata (data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign ready      = !fifo_empty;
  assign overflow   = ovf_q;
  assign parity_err = par_err_q;
  assign frame_err  = frm_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: table of single frames, FIFO fill/overflow,
// pop on the stop strobe, clock glitches, mid-frame reset and (when enabled) timeout.
module tb_ps2_rx_fifo;

  localparam int FIFO_DEPTH  = 8;
  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 200;
  localparam int LW          = $clog2(FIFO_DEPTH) + 1;
  localparam int HALF        = 20;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic rd_en = 1'b0;
  logic err_clr = 1'b0;
  logic [7:0] data;
  logic ready;
  logic [LW-1:0] level;
  logic overflow, parity_err, frame_err;

  int checkCount = 0;
  int errorCount = 0;
  logic [7:0] scoreboard[$];

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic       expPush;
    logic       expParErr;
    logic       expFrmErr;
  } vec_t;

  vec_t vecs[8];

  ps2_rx_fifo #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd_en      (rd_en),
    .err_clr    (err_clr),
    .data       (data),
    .ready      (ready),
    .level      (level),
    .overflow   (overflow),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  function automatic logic oddPar(input logic [7:0] d);
    return ~^d;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Pops n entries on consecutive cycles, comparing each head byte with the scoreboard.
  task automatic popBurst(input int n);
    logic [7:0] exp;
    for (int i = 0; i < n; i++) begin
      if (scoreboard.size() == 0) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL pop_scoreboard: got pop request, expected no entry queued");
      end else begin
        exp = scoreboard.pop_front();
        checkOutput("pop_ready", 32'(ready), 32'd1);
        checkOutput("pop_data", 32'(data), 32'(exp));
      end
      rd_en = 1'b1;
      @(negedge clk);
    end
    rd_en = 1'b0;
  endtask

  // Drives the first nBits bits of a frame (LSB first); optional glitch and pop on the stop strobe.
  task automatic applyStimulus(input logic [10:0] frame, input int nBits, input bit glitch, input bit popAtStop);
    for (int i = 0; i < nBits; i++) begin
      ps2_data = frame[i];
      repeat (HALF / 2) @(negedge clk);
      if (glitch && (i == 3 || i == 6)) begin
        ps2_clk = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge clk);
        ps2_clk = 1'b1;
      end
      repeat (HALF / 2) @(negedge clk);
      ps2_clk = 1'b0;
      if (popAtStop && i == 10) begin
        repeat (FILTER_LEN + 1) @(negedge clk);
        popBurst(1);
        repeat (HALF - FILTER_LEN - 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    repeat (HALF / 2) @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF / 2) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic p, input logic s, input bit glitch, input bit popAtStop);
    applyStimulus({s, p, d, 1'b0}, 11, glitch, popAtStop);
  endtask

  task automatic clearErrors();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{d: 8'h1C, par: 1'b0, stop: 1'b1, expPush: 1'b1, expParErr: 1'b0, expFrmErr: 1'b0};
    vecs[1] = '{d: 8'hF0, par: 1'b0, stop: 1'b1, expPush: 1'b0, expParErr: 1'b1, expFrmErr: 1'b0};
    vecs[2] = '{d: 8'hA5, par: 1'b1, stop: 1'b1, expPush: 1'b1, expParErr: 1'b0, expFrmErr: 1'b0};
    vecs[3] = '{d: 8'h3C, par: 1'b1, stop: 1'b0, expPush: 1'b0, expParErr: 1'b0, expFrmErr: 1'b1};
    vecs[4] = '{d: 8'h07, par: 1'b1, stop: 1'b0, expPush: 1'b0, expParErr: 1'b1, expFrmErr: 1'b1};
    vecs[5] = '{d: 8'hFF, par: 1'b1, stop: 1'b1, expPush: 1'b1, expParErr: 1'b0, expFrmErr: 1'b0};
    vecs[6] = '{d: 8'h00, par: 1'b1, stop: 1'b1, expPush: 1'b1, expParErr: 1'b0, expFrmErr: 1'b0};
    vecs[7] = '{d: 8'h80, par: 1'b0, stop: 1'b1, expPush: 1'b1, expParErr: 1'b0, expFrmErr: 1'b0};

    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 32'(ready), 32'd0);
    checkOutput("reset_level", 32'(level), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    checkOutput("reset_parity_err", 32'(parity_err), 32'd0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
    clrn = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] single-frame table");
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].expPush) scoreboard.push_back(vecs[i].d);
      sendFrame(vecs[i].d, vecs[i].par, vecs[i].stop, 1'b0, 1'b0);
      checkOutput("vec_level", 32'(level), vecs[i].expPush ? 32'd1 : 32'd0);
      checkOutput("vec_ready", 32'(ready), 32'(vecs[i].expPush));
      checkOutput("vec_parity_err", 32'(parity_err), 32'(vecs[i].expParErr));
      checkOutput("vec_frame_err", 32'(frame_err), 32'(vecs[i].expFrmErr));
      checkOutput("vec_overflow", 32'(overflow), 32'd0);
      if (vecs[i].expPush) begin
        popBurst(1);
        checkOutput("vec_ready_after_pop", 32'(ready), 32'd0);
        checkOutput("vec_level_after_pop", 32'(level), 32'd0);
      end
      clearErrors();
      checkOutput("vec_parity_err_clr", 32'(parity_err), 32'd0);
      checkOutput("vec_frame_err_clr", 32'(frame_err), 32'd0);
    end

    $display("[TB] fill past depth");
    for (int i = 1; i <= FIFO_DEPTH + 1; i++) begin
      if (i <= FIFO_DEPTH) scoreboard.push_back(8'(i));
      sendFrame(8'(i), oddPar(8'(i)), 1'b1, 1'b0, 1'b0);
    end
    checkOutput("fill_level", 32'(level), 32'(FIFO_DEPTH));
    checkOutput("fill_overflow", 32'(overflow), 32'd1);
    popBurst(FIFO_DEPTH);
    checkOutput("drain_ready", 32'(ready), 32'd0);
    checkOutput("drain_level", 32'(level), 32'd0);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    checkOutput("empty_pop_level", 32'(level), 32'd0);
    clearErrors();
    checkOutput("overflow_clr", 32'(overflow), 32'd0);

    $display("[TB] pop on stop strobe with full FIFO");
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      scoreboard.push_back(8'h40 + 8'(i));
      sendFrame(8'h40 + 8'(i), oddPar(8'h40 + 8'(i)), 1'b1, 1'b0, 1'b0);
    end
    checkOutput("full_level", 32'(level), 32'(FIFO_DEPTH));
    scoreboard.push_back(8'h55);
    sendFrame(8'h55, oddPar(8'h55), 1'b1, 1'b0, 1'b1);
    checkOutput("strobe_pop_overflow", 32'(overflow), 32'd0);
    checkOutput("strobe_pop_level", 32'(level), 32'(FIFO_DEPTH));
    popBurst(FIFO_DEPTH);
    checkOutput("strobe_drain_level", 32'(level), 32'd0);

    $display("[TB] clock glitches");
    scoreboard.push_back(8'h3A);
    sendFrame(8'h3A, oddPar(8'h3A), 1'b1, 1'b1, 1'b0);
    checkOutput("glitch_level", 32'(level), 32'd1);
    checkOutput("glitch_parity_err", 32'(parity_err), 32'd0);
    checkOutput("glitch_frame_err", 32'(frame_err), 32'd0);
    popBurst(1);

`ifdef PS2_RX_TIMEOUT_EN
    $display("[TB] timeout");
    applyStimulus({1'b1, oddPar(8'h33), 8'h33, 1'b0}, 5, 1'b0, 1'b0);
    repeat (TIMEOUT_CYC + 20) @(negedge clk);
    checkOutput("timeout_frame_err", 32'(frame_err), 32'd1);
    checkOutput("timeout_level", 32'(level), 32'd0);
    clearErrors();
    scoreboard.push_back(8'h29);
    sendFrame(8'h29, oddPar(8'h29), 1'b1, 1'b0, 1'b0);
    checkOutput("post_timeout_level", 32'(level), 32'd1);
    checkOutput("post_timeout_frame_err", 32'(frame_err), 32'd0);
    popBurst(1);
`endif

    $display("[TB] reset mid-frame");
    sendFrame(8'h12, oddPar(8'h12), 1'b1, 1'b0, 1'b0);
    sendFrame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_reset_level", 32'(level), 32'd1);
    checkOutput("pre_reset_parity_err", 32'(parity_err), 32'd1);
    applyStimulus({1'b1, oddPar(8'h6B), 8'h6B, 1'b0}, 4, 1'b0, 1'b0);
    clrn = 1'b0;
    #1;
    checkOutput("midreset_ready", 32'(ready), 32'd0);
    checkOutput("midreset_level", 32'(level), 32'd0);
    checkOutput("midreset_overflow", 32'(overflow), 32'd0);
    checkOutput("midreset_parity_err", 32'(parity_err), 32'd0);
    checkOutput("midreset_frame_err", 32'(frame_err), 32'd0);
    scoreboard.delete();
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (5) @(negedge clk);
    scoreboard.push_back(8'h29);
    sendFrame(8'h29, oddPar(8'h29), 1'b1, 1'b0, 1'b0);
    checkOutput("post_reset_level", 32'(level), 32'd1);
    checkOutput("post_reset_parity_err", 32'(parity_err), 32'd0);
    checkOutput("post_reset_frame_err", 32'(frame_err), 32'd0);
    popBurst(1);
    checkOutput("final_level", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
